// File: rtl/mdio_controller_if.sv
// Request/response and serial-line bundle between the MDIO station-management master and its user.
interface mdio_controller_if;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_IN;
  logic        MDC;
  logic        MDIO_OUT;
  logic        MDIO_OE;
  logic [15:0] RD_DATA;
  logic        DATA_RDY;
  logic        BUSY;
  logic        ERR;

  modport master (
    output MDIO_START, T_DATA, MDIO_IN,
    input  MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY, ERR
  );

  modport slave (
    input  MDIO_START, T_DATA, MDIO_IN,
    output MDC, MDIO_OUT, MDIO_OE, RD_DATA, DATA_RDY, BUSY, ERR
  );
endinterface

// File: rtl/mdio_controller.sv
// Clause-22 MDIO master: serialises one 32-bit frame per request and captures read data.
// Define MDIO_PREAMBLE_EN to prefix every frame with 32 preamble ones.
module mdio_controller #(
  parameter int unsigned MDC_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  mdio_controller_if.slave  bus
);

  localparam int unsigned DivW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(MDC_DIV - 1);

  typedef enum logic [1:0] {StIdle, StPre, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              half_q, half_d;
  logic [5:0]        bit_q, bit_d;
  logic [31:0]       frame_q, frame_d;
  logic              is_read_q, is_read_d;
  logic [15:0]       shreg_q, shreg_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic              mdc_q, mdc_d;
  logic              out_q, out_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;

  logic [5:0] bit_nxt;
  logic       req_ok;

  assign bit_nxt = bit_q - 6'd1;
  assign req_ok  = (bus.T_DATA[31:30] == 2'b01) &&
                   ((bus.T_DATA[29:28] == 2'b01) || (bus.T_DATA[29:28] == 2'b10));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      half_q    <= 1'b0;
      bit_q     <= '0;
      frame_q   <= '0;
      is_read_q <= 1'b0;
      shreg_q   <= '0;
      rd_data_q <= '0;
      mdc_q     <= 1'b0;
      out_q     <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      is_read_q <= is_read_d;
      shreg_q   <= shreg_d;
      rd_data_q <= rd_data_d;
      mdc_q     <= mdc_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    is_read_d = is_read_q;
    shreg_d   = shreg_q;
    rd_data_d = rd_data_q;
    mdc_d     = mdc_q;
    out_d     = out_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    rdy_d     = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        mdc_d  = 1'b0;
        oe_d   = 1'b0;
        out_d  = 1'b0;
        busy_d = 1'b0;
        if (bus.MDIO_START) begin
          if (req_ok) begin
            frame_d   = bus.T_DATA;
            is_read_d = (bus.T_DATA[29:28] == 2'b10);
            busy_d    = 1'b1;
            div_d     = '0;
            half_d    = 1'b0;
            bit_d     = 6'd31;
            oe_d      = 1'b1;
`ifdef MDIO_PREAMBLE_EN
            state_d   = StPre;
            out_d     = 1'b1;
`else
            state_d   = StShift;
            out_d     = bus.T_DATA[31];
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StPre, StShift: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (!half_q) begin
            // Rising MDC: sample the peripheral during read data bits
            half_d = 1'b1;
            mdc_d  = 1'b1;
            if (state_q == StShift && is_read_q && bit_q < 6'd16) begin
              shreg_d = {shreg_q[14:0], bus.MDIO_IN};
            end
          end else begin
            half_d = 1'b0;
            mdc_d  = 1'b0;
            if (bit_q == 6'd0) begin
              if (state_q == StPre) begin
                state_d = StShift;
                bit_d   = 6'd31;
                out_d   = frame_q[31];
                oe_d    = 1'b1;
              end else begin
                state_d = StDone;
                busy_d  = 1'b0;
                oe_d    = 1'b0;
                out_d   = 1'b0;
                if (is_read_q) begin
                  rd_data_d = shreg_q;
                  rdy_d     = 1'b1;
                end
              end
            end else begin
              bit_d = bit_nxt;
              if (state_q == StPre) begin
                out_d = 1'b1;
                oe_d  = 1'b1;
              end else begin
                // Reads release the line from the turnaround onwards
                oe_d  = !is_read_q || (bit_nxt >= 6'd18);
                out_d = oe_d ? frame_q[bit_nxt[4:0]] : 1'b0;
              end
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.MDC      = mdc_q;
  assign bus.MDIO_OUT = out_q;
  assign bus.MDIO_OE  = oe_q;
  assign bus.RD_DATA  = rd_data_q;
  assign bus.DATA_RDY = rdy_q;
  assign bus.BUSY     = busy_q;
  assign bus.ERR      = err_q;

endmodule
